// File: rtl/gpu_apb_cmd_queue_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpu_apb_pkg
// Description : Shared types and constants for the GPU APB command queue.
//               APB protocol FSM state type, default register addresses and
//               bit positions of the fields in the status register.
// Revision    : 1.0 - initial release
// ============================================================================
package gpu_apb_pkg;

  // APB protocol phase tracker. IDLE: no transfer in progress. SETUP: a setup
  // phase was seen at the last edge, so this cycle is the first access cycle.
  // ACCESS: the transfer has been in its access phase for more than one cycle
  // (wait states) or has just completed.
  typedef enum logic [1:0] {
    APB_IDLE   = 2'd0,
    APB_SETUP  = 2'd1,
    APB_ACCESS = 2'd2
  } apb_state_e;

  // Default register map.
  localparam logic [31:0] DEFAULT_CMD_ADDR    = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_STATUS_ADDR = 32'h0000_0004;

  // Status register layout: {zeros, count, full, empty}.
  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 2;

endpackage
`default_nettype wire

// File: rtl/gpu_apb_cmd_queue_fifo.sv
`default_nettype none
// ============================================================================
// Module      : gpu_cmd_fifo
// Description : Synchronous FIFO holding GPU command words.
//               Simultaneous push and pop is legal at any occupancy, including
//               full. Flush clears pointers and occupancy and overrides any
//               push or pop in the same cycle.
// Ports       : clk, n_rst       - clock, asynchronous active-low reset
//               push_i, pop_i     - enqueue wdata_i / dequeue the head
//               flush_i           - discard all entries
//               wdata_i           - word to enqueue
//               rdata_o           - head word (undefined content when empty)
//               empty_o, full_o   - occupancy flags
//               count_o           - current occupancy, 0..DEPTH
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_cmd_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     flush_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic w_empty;
  logic w_full;
  logic w_push;
  logic w_pop;

  assign w_empty = (count_q == '0);
  assign w_full  = (count_q == CNT_W'(DEPTH));

  // A push into a full queue is only safe when the head leaves the same cycle.
  assign w_pop  = pop_i & ~w_empty;
  assign w_push = push_i & (~w_full | w_pop);

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (w_push) wptr_d = wptr_q + PTR_W'(1);
      if (w_pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (w_push && !flush_i) begin
      mem_q[wptr_q] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign empty_o = w_empty;
  assign full_o  = w_full;
  assign count_o = count_q;

endmodule
`default_nettype wire

// File: rtl/gpu_apb_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : gpu_apb_cmd_queue
// Description : APB slave that queues GPU command words for the command
//               decoder. CMD_ADDR (write-only) pushes a word, STATUS_ADDR reads
//               {count, full, empty} and flushes the queue on a write with
//               bit 0 set. Back-pressure via pReady_o when full, pSlvErr_o on
//               illegal accesses, valid/ready handshake toward the consumer.
// Ports       : clk, n_rst                    - clock, async active-low reset
//               pAddr_i, pDataWrite_i         - APB address / write data
//               pSel_i, pEnable_i, pWrite_i   - APB control
//               pDataRead_o, pReady_o,
//               pSlvErr_o                     - APB response
//               command_o, opcode_o,
//               parameters_o                  - head of queue (valid/data)
//               cmd_ready_i                   - consumer accepts the head
//               count_o                       - queue occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module gpu_apb_cmd_queue
  import gpu_apb_pkg::*;
#(
  parameter int          DATA_W      = 32,
  parameter int          OPCODE_W    = 4,
  parameter int          DEPTH       = 8,
  parameter logic [31:0] CMD_ADDR    = DEFAULT_CMD_ADDR,
  parameter logic [31:0] STATUS_ADDR = DEFAULT_STATUS_ADDR
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [31:0]                pAddr_i,
  input  logic [DATA_W-1:0]          pDataWrite_i,
  input  logic                       pSel_i,
  input  logic                       pEnable_i,
  input  logic                       pWrite_i,
  output logic [DATA_W-1:0]          pDataRead_o,
  output logic                       pReady_o,
  output logic                       pSlvErr_o,
  output logic                       command_o,
  output logic [OPCODE_W-1:0]        opcode_o,
  output logic [DATA_W-OPCODE_W-1:0] parameters_o,
  input  logic                       cmd_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  apb_state_e state_q, state_d;

  logic [DATA_W-1:0] w_head;
  logic [DATA_W-1:0] w_status;
  logic [CNT_W-1:0]  w_count;
  logic              w_empty;
  logic              w_full;
  logic              w_pop;
  logic              w_push;
  logic              w_flush;
  logic              w_in_xfer;
  logic              w_violation;
  logic              w_is_cmd;
  logic              w_is_status;
  logic              w_ready;
  logic              w_err;
  logic [DATA_W-1:0] w_rdata;

  // --------------------------------------------------------------------------
  // Command storage
  // --------------------------------------------------------------------------
  gpu_cmd_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .n_rst   (n_rst),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .flush_i (w_flush),
    .wdata_i (pDataWrite_i),
    .rdata_o (w_head),
    .empty_o (w_empty),
    .full_o  (w_full),
    .count_o (w_count)
  );

  // Consumer handshake: the head leaves whenever it is valid and accepted.
  assign w_pop = ~w_empty & cmd_ready_i;

  // --------------------------------------------------------------------------
  // Address decode and response
  // --------------------------------------------------------------------------
  assign w_is_cmd    = (pAddr_i == CMD_ADDR);
  assign w_is_status = (pAddr_i == STATUS_ADDR);

  // The state register records the phase seen at the previous edge, so any
  // non-IDLE state with pEnable high is an access cycle of a proper transfer.
  // pEnable high while IDLE means the master skipped the setup phase.
  assign w_in_xfer   = (state_q != APB_IDLE) & pSel_i & pEnable_i;
  assign w_violation = (state_q == APB_IDLE) & pSel_i & pEnable_i;

  always_comb begin
    w_status = '0;
    w_status[STATUS_EMPTY_BIT]             = w_empty;
    w_status[STATUS_FULL_BIT]              = w_full;
    w_status[STATUS_COUNT_LSB +: CNT_W]    = w_count;
  end

  always_comb begin
    w_ready = 1'b1;
    w_err   = 1'b0;
    w_rdata = '0;
    w_push  = 1'b0;
    w_flush = 1'b0;
    if (w_violation) begin
      w_err = 1'b1;
    end else if (w_in_xfer) begin
      if (pWrite_i) begin
        if (w_is_cmd) begin
          // A full queue can still take the word if the head pops this cycle.
          if (!w_full || w_pop) begin
            w_push = 1'b1;
          end else begin
            w_ready = 1'b0;
          end
        end else if (w_is_status) begin
          w_flush = pDataWrite_i[0];
        end else begin
          w_err = 1'b1;
        end
      end else begin
        if (w_is_status) begin
          w_rdata = w_status;
        end else begin
          w_err = 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // APB protocol FSM
  // --------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      APB_IDLE: begin
        if (pSel_i && !pEnable_i) state_d = APB_SETUP;
      end
      APB_SETUP: begin
        state_d = APB_ACCESS;
      end
      APB_ACCESS: begin
        if (w_ready) begin
          state_d = (pSel_i && !pEnable_i) ? APB_SETUP : APB_IDLE;
        end
      end
      default: begin
        state_d = APB_IDLE;
      end
    endcase
    if (!pSel_i) state_d = APB_IDLE;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= APB_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign pReady_o    = w_ready;
  assign pSlvErr_o   = w_err;
  assign pDataRead_o = w_rdata;

  assign command_o    = ~w_empty;
  assign opcode_o     = w_empty ? '0 : w_head[DATA_W-1 -: OPCODE_W];
  assign parameters_o = w_empty ? '0 : w_head[DATA_W-OPCODE_W-1:0];
  assign count_o      = w_count;

endmodule
`default_nettype wire

// File: tb/tb_gpu_apb_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpu_apb_cmd_queue
// Description : Self-checking bench for gpu_apb_cmd_queue. Words pushed over
//               APB are recorded in an expected-word queue; words handed to the
//               consumer are recorded by a monitor and compared in order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpu_apb_cmd_queue;

  localparam int          DATA_W   = 32;
  localparam int          OPCODE_W = 4;
  localparam int          DEPTH    = 8;
  localparam logic [31:0] CMD_A    = 32'h0000_0000;
  localparam logic [31:0] STAT_A   = 32'h0000_0004;

  logic                       clk = 1'b0;
  logic                       n_rst = 1'b0;
  logic [31:0]                pAddr = '0;
  logic [DATA_W-1:0]          pDataWrite = '0;
  logic                       pSel = 1'b0;
  logic                       pEnable = 1'b0;
  logic                       pWrite = 1'b0;
  logic [DATA_W-1:0]          pDataRead_o;
  logic                       pReady_o;
  logic                       pSlvErr_o;
  logic                       command_o;
  logic [OPCODE_W-1:0]        opcode_o;
  logic [DATA_W-OPCODE_W-1:0] parameters_o;
  logic                       cmd_ready = 1'b0;
  logic [$clog2(DEPTH):0]     count_o;

  int n_vec = 0;
  int n_err = 0;

  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];
  int          got_rd = 0;

  gpu_apb_cmd_queue #(
    .DATA_W      (DATA_W),
    .OPCODE_W    (OPCODE_W),
    .DEPTH       (DEPTH),
    .CMD_ADDR    (CMD_A),
    .STATUS_ADDR (STAT_A)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .pAddr_i      (pAddr),
    .pDataWrite_i (pDataWrite),
    .pSel_i       (pSel),
    .pEnable_i    (pEnable),
    .pWrite_i     (pWrite),
    .pDataRead_o  (pDataRead_o),
    .pReady_o     (pReady_o),
    .pSlvErr_o    (pSlvErr_o),
    .command_o    (command_o),
    .opcode_o     (opcode_o),
    .parameters_o (parameters_o),
    .cmd_ready_i  (cmd_ready),
    .count_o      (count_o)
  );

  always #5 clk = ~clk;

  // Record every word the consumer takes (handshake sampled mid-cycle).
  always @(negedge clk) begin
    if (n_rst && command_o && cmd_ready) got_q.push_back({opcode_o, parameters_o});
  end

  // One full APB transfer starting at posedge+1; returns at posedge+1 after
  // the completing access cycle.
  task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rd, output logic err);
    int waits;
    pSel = 1'b1; pEnable = 1'b0; pWrite = wr; pAddr = addr; pDataWrite = wdata;
    @(posedge clk); #1;
    pEnable = 1'b1;
    rd = '0; err = 1'b0; waits = 0;
    while (1) begin
      @(negedge clk);
      if (pReady_o) begin
        rd = pDataRead_o; err = pSlvErr_o;
        break;
      end
      waits++;
      if (waits > 64) begin
        n_vec++; n_err++;
        $display("FAIL apb_timeout: pReady_o=%0b required 1 within 64 cycles", pReady_o);
        break;
      end
    end
    @(posedge clk); #1;
    pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
  endtask

  // Let the consumer take everything; bounded.
  task automatic drain();
    int k;
    k = 0;
    cmd_ready = 1'b1;
    @(negedge clk);
    while (command_o === 1'b1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (command_o !== 1'b0) begin
      n_err++;
      $display("FAIL drain_timeout: command_o=%0b required 0", command_o);
    end
    @(posedge clk); #1;
    cmd_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 n_rst = 1'b1;
    @(negedge clk);
    n_vec++; if (pReady_o !== 1'b1) begin n_err++; $display("FAIL rst_pready: got %0b want 1", pReady_o); end
    n_vec++; if (pSlvErr_o !== 1'b0) begin n_err++; $display("FAIL rst_pslverr: got %0b want 0", pSlvErr_o); end
    n_vec++; if (pDataRead_o !== '0) begin n_err++; $display("FAIL rst_prdata: got %h want 0", pDataRead_o); end
    n_vec++; if (command_o !== 1'b0) begin n_err++; $display("FAIL rst_command: got %0b want 0", command_o); end
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL rst_count: got %0d want 0", count_o); end
    n_vec++; if ({opcode_o, parameters_o} !== 32'h0) begin
      n_err++; $display("FAIL rst_head: got %h want 0", {opcode_o, parameters_o});
    end
  endtask

  task automatic test_push_single();
    logic [31:0] rd;
    logic        er;
    logic [31:0] w;
    apb_xfer(1'b1, CMD_A, 32'h3000_00AB, rd, er);
    exp_q.push_back(32'h3000_00AB);
    @(negedge clk);
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL push_err: got %0b want 0", er); end
    n_vec++; if (command_o !== 1'b1) begin n_err++; $display("FAIL push_command: got %0b want 1", command_o); end
    n_vec++; if (opcode_o !== 4'h3) begin n_err++; $display("FAIL push_opcode: got %h want 3", opcode_o); end
    n_vec++; if (parameters_o !== 28'h00000AB) begin
      n_err++; $display("FAIL push_params: got %h want 00000ab", parameters_o);
    end
    n_vec++; if (count_o !== 4'd1) begin n_err++; $display("FAIL push_count: got %0d want 1", count_o); end
    drain();
    while (got_rd < got_q.size()) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL order: got %h want no word", got_q[got_rd]);
      end else begin
        w = exp_q.pop_front();
        if (got_q[got_rd] !== w) begin n_err++; $display("FAIL order: got %h want %h", got_q[got_rd], w); end
      end
      got_rd++;
    end
  endtask

  task automatic test_full_backpressure();
    logic [31:0] rd;
    logic        er;
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      w = {4'(i + 1), 28'(32'h0ABC_0000 + i * 17)};
      apb_xfer(1'b1, CMD_A, w, rd, er);
      exp_q.push_back(w);
    end
    @(negedge clk);
    n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL full_count: got %0d want 8", count_o); end
    // Ninth write: must stall while the consumer is idle.
    w = 32'hF123_4567;
    pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddr = CMD_A; pDataWrite = w;
    @(posedge clk); #1 pEnable = 1'b1;
    @(negedge clk);
    n_vec++; if (pReady_o !== 1'b0) begin n_err++; $display("FAIL full_wait1: pReady_o got %0b want 0", pReady_o); end
    @(posedge clk); #1;
    @(negedge clk);
    n_vec++; if (pReady_o !== 1'b0) begin n_err++; $display("FAIL full_wait2: pReady_o got %0b want 0", pReady_o); end
    @(posedge clk); #1 cmd_ready = 1'b1;
    @(negedge clk);
    n_vec++; if (pReady_o !== 1'b1) begin n_err++; $display("FAIL full_pop_ready: got %0b want 1", pReady_o); end
    n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL full_pop_count: got %0d want 8", count_o); end
    exp_q.push_back(w);
    @(posedge clk); #1;
    cmd_ready = 1'b0; pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    @(negedge clk);
    n_vec++; if (count_o !== 4'd8) begin n_err++; $display("FAIL full_after_count: got %0d want 8", count_o); end
    n_vec++; if ({opcode_o, parameters_o} !== exp_q[1]) begin
      n_err++; $display("FAIL full_after_head: got %h want %h", {opcode_o, parameters_o}, exp_q[1]);
    end
    drain();
    n_vec++; if (got_q.size() - got_rd != 9) begin
      n_err++; $display("FAIL full_pop_total: got %0d want 9", got_q.size() - got_rd);
    end
    while (got_rd < got_q.size()) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL order: got %h want no word", got_q[got_rd]);
      end else begin
        w = exp_q.pop_front();
        if (got_q[got_rd] !== w) begin n_err++; $display("FAIL order: got %h want %h", got_q[got_rd], w); end
      end
      got_rd++;
    end
  endtask

  // Back-to-back transfers with pops interleaved; both pointers wrap.
  task automatic test_wrap();
    logic [31:0] rd;
    logic        er;
    logic [31:0] w;
    int          base;
    base = got_rd;
    for (int i = 0; i < 12; i++) begin
      cmd_ready = (i % 3 != 2);
      w = {4'(i), 28'(32'h0555_0000 ^ (i * 32'h1111))};
      apb_xfer(1'b1, CMD_A, w, rd, er);
      exp_q.push_back(w);
    end
    drain();
    n_vec++; if (got_q.size() - base != 12) begin
      n_err++; $display("FAIL wrap_total: got %0d want 12", got_q.size() - base);
    end
    while (got_rd < got_q.size()) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL order: got %h want no word", got_q[got_rd]);
      end else begin
        w = exp_q.pop_front();
        if (got_q[got_rd] !== w) begin n_err++; $display("FAIL order: got %h want %h", got_q[got_rd], w); end
      end
      got_rd++;
    end
    @(negedge clk);
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL wrap_count: got %0d want 0", count_o); end
  endtask

  task automatic test_status_flush();
    logic [31:0] rd;
    logic        er;
    for (int i = 0; i < 3; i++) begin
      apb_xfer(1'b1, CMD_A, 32'h7000_0000 + i, rd, er);
      exp_q.push_back(32'h7000_0000 + i);
    end
    apb_xfer(1'b0, STAT_A, '0, rd, er);
    n_vec++; if (rd !== 32'h0000_000C) begin n_err++; $display("FAIL status_read: got %h want 0000000c", rd); end
    n_vec++; if (er !== 1'b0) begin n_err++; $display("FAIL status_err: got %0b want 0", er); end
    apb_xfer(1'b1, STAT_A, 32'h1, rd, er);
    exp_q.delete();
    @(negedge clk);
    n_vec++; if (command_o !== 1'b0) begin n_err++; $display("FAIL flush_command: got %0b want 0", command_o); end
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL flush_count: got %0d want 0", count_o); end
    n_vec++; if (got_rd != got_q.size()) begin
      n_err++; $display("FAIL flush_pops: got %0d want 0", got_q.size() - got_rd);
    end
  endtask

  task automatic test_errors();
    logic [31:0] rd;
    logic        er;
    logic [31:0] w;
    apb_xfer(1'b1, CMD_A, 32'h5000_0042, rd, er);
    exp_q.push_back(32'h5000_0042);
    apb_xfer(1'b0, CMD_A, '0, rd, er);
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL err_read_cmd: got %0b want 1", er); end
    apb_xfer(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er);
    n_vec++; if (er !== 1'b1) begin n_err++; $display("FAIL err_bad_addr: got %0b want 1", er); end
    @(posedge clk); #1;
    // Access phase with no preceding setup phase.
    pSel = 1'b1; pEnable = 1'b1; pWrite = 1'b1; pAddr = CMD_A; pDataWrite = 32'h9999_9999;
    @(negedge clk);
    n_vec++; if ({pReady_o, pSlvErr_o} !== 2'b11) begin
      n_err++; $display("FAIL err_no_setup: got ready/err %b want 11", {pReady_o, pSlvErr_o});
    end
    @(posedge clk); #1;
    pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    @(negedge clk);
    n_vec++; if (count_o !== 4'd1) begin n_err++; $display("FAIL err_count: got %0d want 1", count_o); end
    n_vec++; if ({opcode_o, parameters_o} !== 32'h5000_0042) begin
      n_err++; $display("FAIL err_head: got %h want 50000042", {opcode_o, parameters_o});
    end
    drain();
    while (got_rd < got_q.size()) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL order: got %h want no word", got_q[got_rd]);
      end else begin
        w = exp_q.pop_front();
        if (got_q[got_rd] !== w) begin n_err++; $display("FAIL order: got %h want %h", got_q[got_rd], w); end
      end
      got_rd++;
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd;
    logic        er;
    logic [31:0] w;
    for (int i = 0; i < DEPTH; i++) begin
      apb_xfer(1'b1, CMD_A, 32'hC000_0100 + i, rd, er);
    end
    pSel = 1'b1; pEnable = 1'b0; pWrite = 1'b1; pAddr = CMD_A; pDataWrite = 32'hEEEE_EEEE;
    @(posedge clk); #1 pEnable = 1'b1;
    @(negedge clk);
    n_vec++; if (pReady_o !== 1'b0) begin n_err++; $display("FAIL rw_wait: pReady_o got %0b want 0", pReady_o); end
    #2;
    n_rst = 1'b0; pSel = 1'b0; pEnable = 1'b0; pWrite = 1'b0;
    #1;
    n_vec++; if ({pReady_o, pSlvErr_o, command_o} !== 3'b100) begin
      n_err++; $display("FAIL rw_ctrl: got ready/err/cmd %b want 100", {pReady_o, pSlvErr_o, command_o});
    end
    n_vec++; if (count_o !== '0) begin n_err++; $display("FAIL rw_count: got %0d want 0", count_o); end
    n_vec++; if ({opcode_o, parameters_o} !== 32'h0 || pDataRead_o !== '0) begin
      n_err++; $display("FAIL rw_data: got head %h rdata %h want 0 0", {opcode_o, parameters_o}, pDataRead_o);
    end
    @(posedge clk); #1 n_rst = 1'b1;
    exp_q.delete();
    got_rd = got_q.size();
    @(negedge clk);
    n_vec++; if (count_o !== '0 || command_o !== 1'b0) begin
      n_err++; $display("FAIL rw_release: got count %0d cmd %0b want 0 0", count_o, command_o);
    end
    apb_xfer(1'b1, CMD_A, 32'h2468_ACE0, rd, er);
    exp_q.push_back(32'h2468_ACE0);
    @(negedge clk);
    n_vec++; if ({opcode_o, parameters_o} !== 32'h2468_ACE0 || count_o !== 4'd1) begin
      n_err++; $display("FAIL rw_fresh: got head %h count %0d want 2468ace0 1", {opcode_o, parameters_o}, count_o);
    end
    drain();
    while (got_rd < got_q.size()) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++; $display("FAIL order: got %h want no word", got_q[got_rd]);
      end else begin
        w = exp_q.pop_front();
        if (got_q[got_rd] !== w) begin n_err++; $display("FAIL order: got %h want %h", got_q[got_rd], w); end
      end
      got_rd++;
    end
  endtask

  initial begin
    test_reset();
    test_push_single();
    test_full_backpressure();
    test_wrap();
    test_status_flush();
    test_errors();
    test_reset_in_wait();
    n_vec++;
    if (exp_q.size() != 0) begin
      n_err++; $display("FAIL leftover: got %0d expected words unconsumed want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/gpu_apb_cmd_queue.md
# gpu_apb_cmd_queue

APB slave that accepts GPU command words from the host bus and buffers them in a parametrised FIFO ahead of the command decoder. It is the successor to the single-shot APB command decoder and adds the following:
- address decode;
- a read-back status register;
- `pReady` back-pressure when the queue is full;
- `pSlvErr` on illegal accesses;
- a valid/ready handshake toward the consumer.

## Interface
Parameters:
- `DATA_W`, 32: APB data width and command word width.
- `OPCODE_W`, 4: opcode field width, taken from the command word MSBs.
- `DEPTH`, 8: FIFO entries; power of two, ≥ 2.
- `CMD_ADDR`, 32'h0000_0000: write-only command push address.
- `STATUS_ADDR`, 32'h0000_0004: status read / flush write address.

Ports:
- `clk` in 1: single clock; all state on its rising edge.
- `n_rst` in 1: asynchronous, active-low reset.
- `pAddr_i` in 32: APB address.
- `pDataWrite_i` in DATA_W: APB write data.
- `pSel_i`, `pEnable_i`, `pWrite_i` in 1 each: APB control.
- `pDataRead_o` out DATA_W: APB read data.
- `pReady_o` out 1: transfer completes this cycle.
- `pSlvErr_o` out 1: error response; valid only while `pReady_o`=1.
- `command_o` out 1: head-of-queue valid.
- `opcode_o` out OPCODE_W: head word `[DATA_W-1 -: OPCODE_W]`.
- `parameters_o` out DATA_W-OPCODE_W: head word `[DATA_W-OPCODE_W-1:0]`.
- `cmd_ready_i` in 1: consumer accepts the head this cycle.
- `count_o` out $clog2(DEPTH)+1: current occupancy.

## Operation
APB protocol FSM, states IDLE, SETUP, ACCESS:
- IDLE → SETUP on `pSel_i`&!`pEnable_i`.
- SETUP → ACCESS unconditionally.
- ACCESS stays in ACCESS while `pReady_o`=0.
- ACCESS with `pReady_o`=1 → SETUP if `pSel_i`&!`pEnable_i`, else IDLE.
- Any state → IDLE if `pSel_i`=0.

Responses in ACCESS (`pSel_i`&`pEnable_i`):
- Write to CMD_ADDR, not full: `pReady_o`=1, push `pDataWrite_i`.
- Write to CMD_ADDR, full with no pop this cycle: `pReady_o`=0 (wait state), no push.
- Write to CMD_ADDR, full with a pop this cycle: `pReady_o`=1, push accepted.
- Write to STATUS_ADDR with `pDataWrite_i[0]`=1: flush the queue (pointers and count to 0). `pReady_o`=1. Other bits are ignored.
- Read STATUS_ADDR: `pReady_o`=1, `pDataRead_o`={zeros, `count_o`, full, empty} with empty at bit 0 and full at bit 1.
- Read CMD_ADDR, or any other address: `pReady_o`=1, `pSlvErr_o`=1, no side effect.

Protocol violation:
- `pSel_i`&`pEnable_i` while FSM is IDLE (no setup phase): `pReady_o`=1, `pSlvErr_o`=1, no push or flush.

Idle-bus outputs:
- Outside ACCESS, `pReady_o`=1, `pSlvErr_o`=0, `pDataRead_o`=0.

Consumer side:
- `command_o` = !empty.
- `opcode_o`/`parameters_o` show the head word when non-empty, otherwise 0 (matches legacy zero-when-idle behaviour).
- Pop happens when `command_o`&`cmd_ready_i`.

Arithmetic:
- Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Count updates +1 on push only, -1 on pop only, unchanged on both.

## Timing
- Reset values: FSM=IDLE, pointers=0, `count_o`=0, `command_o`=0, `opcode_o`=0, `parameters_o`=0, `pReady_o`=1, `pSlvErr_o`=0, `pDataRead_o`=0.
- Reset mid-transfer or mid-wait-state discards all queued commands and any in-flight push.
- Push latency: a word written in ACCESS cycle N appears at the head (if the queue was empty) with `command_o`=1 in cycle N+1.
- Pop: the head advances at the rising edge where `command_o`&`cmd_ready_i`; the next word is visible the following cycle.
- Simultaneous push and pop: allowed at any occupancy, including full. Count is unchanged.
- Flush in the same cycle as a pop: flush wins and the count becomes 0. The consumer still treats that cycle's handshake as consumed.
- Wait states: `pReady_o`, `pSlvErr_o` and `pDataRead_o` are combinational from FSM state, address, and full/pop. There is no added latency beyond APB's two-phase minimum.
- STATUS reads report pre-edge occupancy.

## Structure
- Package `gpu_apb_pkg`:
  - APB FSM enum type;
  - default CMD_ADDR and STATUS_ADDR constants;
  - status bit positions (EMPTY=0, FULL=1, COUNT_LSB=2).
- Sub-module `gpu_cmd_fifo`, parametrised by WIDTH and DEPTH:
  - inputs push, pop, flush, wdata;
  - outputs rdata, empty, full, count.
- The top level holds the APB FSM, address decode and response muxing.

## Test plan
- Write 32'h3000_00AB to CMD_ADDR with `cmd_ready_i`=0 → next cycle `command_o`=1, `opcode_o`=4'h3, `parameters_o`=28'h00000AB, `count_o`=1.
- Write 8 commands with `cmd_ready_i`=0, then a 9th → 9th transfer holds `pReady_o`=0. Raise `cmd_ready_i` for one cycle → `pReady_o`=1 that cycle, `count_o` stays 8, FIFO order is preserved.
- Push 12 words with pops interleaved so both pointers wrap past 7 → the consumer receives all 12 in order and `count_o` ends at 0.
- Read STATUS_ADDR with 3 entries queued → `pDataRead_o`=32'h0000_000C. Then write 32'h1 to STATUS_ADDR → `command_o`=0 and `count_o`=0 next cycle.
- Read CMD_ADDR, write to 32'h10, and assert `pEnable_i` without a setup phase → each gives `pReady_o`=1, `pSlvErr_o`=1 and leaves the queue unchanged.
- Assert `n_rst`=0 during a full-queue wait state → all outputs take their reset values immediately, and the queue is empty after release.
